// File: rtl/vend_txn_controller.sv
// vend_txn_controller
//   Transaction controller for a multi-item vending unit. Accumulates coin
//   credit, checks selections against fixed prices, then drives one shared
//   dispenser and one 5-cent change hopper over req/ack handshakes. A
//   per-request watchdog raises a sticky fault flag.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   coin_in_en, coin_val  coin pulse; coin_val 0 = 5c, 1 = 10c
//   sel_valid, sel_id     selection pulse and item index 0..3
//   cancel                refund-all pulse
//   disp_req/disp_item    dispense request and item, held until disp_ack
//   disp_ack              dispenser done
//   chg_req/chg_ack       eject one 5c coin / coin ejected
//   credit                current credit in cents
//   coin_reject           pulse: coin not credited
//   sel_reject            pulse: selection refused
//   busy                  high in DISPENSE or CHANGE
//   fault                 sticky watchdog fault, cleared only by reset
//   state_dbg             current FSM state (0 IDLE, 1 DISPENSE, 2 CHANGE, 3 HALT)
//
// Handshake: a req is raised by this block and held high until the
// matching ack is sampled high on a clock edge while the req is high; an
// ack seen while its req is low is ignored. Every output is registered.
module vend_txn_controller #(
    parameter int CREDIT_W    = 8,
    parameter int MAX_CREDIT  = 95,
    parameter int PRICE_0     = 15,
    parameter int PRICE_1     = 20,
    parameter int PRICE_2     = 25,
    parameter int PRICE_3     = 50,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                coin_in_en,
    input  logic                coin_val,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    output logic                disp_req,
    output logic [1:0]          disp_item,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic                busy,
    output logic                fault,
    output logic [1:0]          state_dbg
);
    localparam int CW1     = CREDIT_W + 1;
    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 2);

    // Credit arithmetic is done one bit wider so sums can never wrap.
    localparam logic [CREDIT_W:0]  NICKEL    = CW1'(5);
    localparam logic [CREDIT_W:0]  DIME      = CW1'(10);
    localparam logic [CREDIT_W:0]  MAX_X     = CW1'(MAX_CREDIT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(ACK_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_CHANGE   = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [TIMER_W-1:0]  timer, timer_d;
    logic [CREDIT_W:0]   price_lat, price_d;
    logic [CREDIT_W-1:0] credit_d;
    logic                disp_req_d, chg_req_d, coin_reject_d, sel_reject_d;
    logic                busy_d, fault_d;
    logic [1:0]          disp_item_d;

    logic [CREDIT_W:0]   credit_x, coin_amt, coin_sum, credit_after_coin, sel_price;
    logic                coin_take, sel_ok;
    logic                disp_done, disp_timeout, chg_done, chg_timeout;

    assign state_dbg = state;
    assign credit_x  = {1'b0, credit};
    assign coin_amt  = coin_val ? DIME : NICKEL;
    assign coin_sum  = credit_x + coin_amt;

    always_comb begin
        case (sel_id)
            2'd0:    sel_price = CW1'(PRICE_0);
            2'd1:    sel_price = CW1'(PRICE_1);
            2'd2:    sel_price = CW1'(PRICE_2);
            default: sel_price = CW1'(PRICE_3);
        endcase
    end

    // Coins and selections are only honoured in IDLE without a fault.
    // The price check uses the credit before any same-cycle coin.
    assign coin_take = (state == S_IDLE) && coin_in_en && !fault && (coin_sum <= MAX_X);
    assign credit_after_coin = coin_take ? coin_sum : credit_x;
    assign sel_ok = (state == S_IDLE) && sel_valid && !cancel && !fault &&
                    (credit_x >= sel_price);

    assign disp_done    = (state == S_DISPENSE) && disp_req && disp_ack;
    assign disp_timeout = (state == S_DISPENSE) && disp_req && !disp_ack && (timer == TIMER_MAX);
    assign chg_done     = (state == S_CHANGE) && chg_req && chg_ack;
    assign chg_timeout  = (state == S_CHANGE) && chg_req && !chg_ack && (timer == TIMER_MAX);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            credit      <= '0;
            disp_req    <= 1'b0;
            disp_item   <= 2'd0;
            chg_req     <= 1'b0;
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            timer       <= '0;
            price_lat   <= '0;
        end else begin
            state       <= state_d;
            credit      <= credit_d;
            disp_req    <= disp_req_d;
            disp_item   <= disp_item_d;
            chg_req     <= chg_req_d;
            coin_reject <= coin_reject_d;
            sel_reject  <= sel_reject_d;
            busy        <= busy_d;
            fault       <= fault_d;
            timer       <= timer_d;
            price_lat   <= price_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (cancel) begin
                    if (credit_after_coin != '0) state_d = S_CHANGE;
                end else if (sel_ok) begin
                    state_d = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                if (disp_done)         state_d = (credit != '0) ? S_CHANGE : S_IDLE;
                else if (disp_timeout) state_d = S_CHANGE;
            end
            S_CHANGE: begin
                if (chg_done && (credit_x == NICKEL)) state_d = S_IDLE;
                else if (chg_timeout)                 state_d = S_HALT;
                else if (!chg_req && (credit == '0))  state_d = S_IDLE;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        credit_d      = credit;
        disp_req_d    = disp_req;
        disp_item_d   = disp_item;
        chg_req_d     = chg_req;
        fault_d       = fault;
        timer_d       = timer;
        price_d       = price_lat;
        coin_reject_d = coin_in_en && !coin_take;
        sel_reject_d  = sel_valid && !sel_ok;
        case (state)
            S_IDLE: begin
                credit_d = CREDIT_W'(credit_after_coin);
                if (cancel) begin
                    if (credit_after_coin != '0) begin
                        chg_req_d = 1'b1;
                        timer_d   = '0;
                    end
                end else if (sel_ok) begin
                    credit_d    = CREDIT_W'(credit_after_coin - sel_price);
                    disp_req_d  = 1'b1;
                    disp_item_d = sel_id;
                    price_d     = sel_price;
                    timer_d     = '0;
                end
            end
            S_DISPENSE: begin
                if (disp_done) begin
                    disp_req_d = 1'b0;
                    if (credit != '0) begin
                        chg_req_d = 1'b1;
                        timer_d   = '0;
                    end
                end else if (disp_timeout) begin
                    // Nothing was dispensed: refund the price and pay it all out.
                    disp_req_d = 1'b0;
                    credit_d   = CREDIT_W'(credit_x + price_lat);
                    fault_d    = 1'b1;
                    chg_req_d  = 1'b1;
                    timer_d    = '0;
                end else if (disp_req) begin
                    timer_d = timer + TIMER_ONE;
                end
            end
            S_CHANGE: begin
                if (chg_done) begin
                    // Drop req for one cycle so every coin is a distinct handshake.
                    credit_d  = CREDIT_W'(credit_x - NICKEL);
                    chg_req_d = 1'b0;
                end else if (chg_timeout) begin
                    chg_req_d = 1'b0;
                    fault_d   = 1'b1;
                end else if (chg_req) begin
                    timer_d = timer + TIMER_ONE;
                end else if (credit != '0) begin
                    chg_req_d = 1'b1;
                    timer_d   = '0;
                end
            end
            default: begin
                disp_req_d = 1'b0;
                chg_req_d  = 1'b0;
            end
        endcase
        busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
    end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller. Inputs change 1 time unit
// after a rising edge and outputs are sampled at that same point, well away
// from the active edge.
module tb_vend_txn_controller;
    localparam int P0 = 15;
    localparam int P1 = 20;
    localparam int P2 = 25;
    localparam int P3 = 50;
    localparam int MAXC = 95;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       coin_in_en = 1'b0;
    logic       coin_val = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic       disp_req, chg_req, coin_reject, sel_reject, busy, fault;
    logic [1:0] disp_item, state_dbg;
    logic [7:0] credit;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    vend_txn_controller dut (
        .clk(clk), .reset_n(reset_n), .coin_in_en(coin_in_en), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .disp_req(disp_req), .disp_item(disp_item), .disp_ack(disp_ack),
        .chg_req(chg_req), .chg_ack(chg_ack), .credit(credit),
        .coin_reject(coin_reject), .sel_reject(sel_reject), .busy(busy),
        .fault(fault), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_coin(input logic v);
        coin_in_en = 1'b1;
        coin_val   = v;
        tick();
        coin_in_en = 1'b0;
    endtask

    task automatic drive_sel(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic drive_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic drive_disp_ack();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
    endtask

    // Services the hopper until the controller leaves CHANGE. Reports coins
    // ejected and how often req failed to drop right after an ack.
    task automatic pay_change(output int n, output int rtz_bad, output bit ok);
        int cyc;
        n = 0;
        rtz_bad = 0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 3000) begin
            if (chg_req === 1'b1) begin
                repeat ($urandom_range(0, 2)) tick();
                chg_ack = 1'b1;
                tick();
                chg_ack = 1'b0;
                n++;
                if (chg_req !== 1'b0) rtz_bad++;
            end else begin
                tick();
            end
            cyc++;
        end
        ok = (busy === 1'b0);
    endtask

    function automatic int price_of(input logic [1:0] id);
        case (id)
            2'd0: return P0;
            2'd1: return P1;
            2'd2: return P2;
            default: return P3;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({disp_req, disp_item, chg_req, credit, coin_reject, sel_reject, busy, fault, state_dbg} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {disp_req, disp_item, chg_req, credit, coin_reject, sel_reject, busy, fault, state_dbg});
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (credit !== 8'd0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL reset_release: credit %0d state %0d expected 0 0", credit, state_dbg);
        end
    endtask

    task automatic test_exact_pay();
        int mc = 0;
        for (int i = 0; i < 3; i++) begin
            mc += 5;
            exp_q.push_back(8'(mc));
            drive_coin(1'b0);
            exp_v = exp_q.pop_front();
            checks++;
            if (credit !== exp_v || coin_reject !== 1'b0) begin
                failures++;
                $display("FAIL exact_coin: credit %0d reject %b expected %0d 0", credit, coin_reject, exp_v);
            end
        end
        exp_q.push_back(8'd0);
        drive_sel(2'd0);
        exp_v = exp_q.pop_front();
        checks++;
        if (disp_req !== 1'b1 || disp_item !== exp_v[1:0] || credit !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL exact_sel: req %b item %0d credit %0d busy %b expected 1 %0d 0 1",
                     disp_req, disp_item, credit, busy, exp_v[1:0]);
        end
        drive_disp_ack();
        checks++;
        if (disp_req !== 1'b0 || chg_req !== 1'b0 || state_dbg !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL exact_ack: req %b chg %b state %0d busy %b expected 0 0 0 0",
                     disp_req, chg_req, state_dbg, busy);
        end
        repeat (3) tick();
        checks++;
        if (chg_req !== 1'b0 || credit !== 8'd0) begin
            failures++;
            $display("FAIL exact_no_change: chg %b credit %0d expected 0 0", chg_req, credit);
        end
    endtask

    task automatic test_change();
        int n, rb;
        bit ok;
        drive_coin(1'b1);
        drive_coin(1'b1);
        drive_sel(2'd0);
        checks++;
        if (credit !== 8'd5 || disp_req !== 1'b1) begin
            failures++;
            $display("FAIL change_sel: credit %0d req %b expected 5 1", credit, disp_req);
        end
        repeat (2) tick();
        checks++;
        if (disp_req !== 1'b1 || disp_item !== 2'd0) begin
            failures++;
            $display("FAIL change_hold: req %b item %0d expected 1 0", disp_req, disp_item);
        end
        drive_disp_ack();
        checks++;
        if (chg_req !== 1'b1 || state_dbg !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL change_enter: chg %b state %0d busy %b expected 1 2 1", chg_req, state_dbg, busy);
        end
        exp_q.push_back(8'd1);
        pay_change(n, rb, ok);
        exp_v = exp_q.pop_front();
        checks++;
        if (!ok || n != int'(exp_v) || rb != 0 || credit !== 8'd0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL change_pay: coins %0d rtz_bad %0d credit %0d ok %b expected %0d 0 0 1",
                     n, rb, credit, ok, exp_v);
        end
    endtask

    task automatic test_sel_reject();
        int n, rb;
        bit ok;
        drive_coin(1'b1);
        drive_sel(2'd1);
        checks++;
        if (sel_reject !== 1'b1 || credit !== 8'd10 || disp_req !== 1'b0) begin
            failures++;
            $display("FAIL sel_reject: rej %b credit %0d req %b expected 1 10 0", sel_reject, credit, disp_req);
        end
        tick();
        checks++;
        if (sel_reject !== 1'b0) begin
            failures++;
            $display("FAIL sel_reject_pulse: rej %b expected 0", sel_reject);
        end
        drive_cancel();
        pay_change(n, rb, ok);
        checks++;
        if (!ok || n != 2 || credit !== 8'd0) begin
            failures++;
            $display("FAIL reject_refund: coins %0d credit %0d expected 2 0", n, credit);
        end
    endtask

    task automatic test_ceiling();
        int n, rb;
        bit ok;
        repeat (9) drive_coin(1'b1);
        drive_coin(1'b1);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd90) begin
            failures++;
            $display("FAIL ceiling_reject: rej %b credit %0d expected 1 90", coin_reject, credit);
        end
        drive_cancel();
        exp_q.push_back(8'd18);
        pay_change(n, rb, ok);
        exp_v = exp_q.pop_front();
        checks++;
        if (!ok || n != int'(exp_v) || rb != 0 || credit !== 8'd0) begin
            failures++;
            $display("FAIL ceiling_refund: coins %0d rtz_bad %0d credit %0d expected %0d 0 0", n, rb, credit, exp_v);
        end
        // Exactly MAX_CREDIT is accepted, one nickel more is not.
        repeat (9) drive_coin(1'b1);
        drive_coin(1'b0);
        checks++;
        if (coin_reject !== 1'b0 || credit !== 8'(MAXC)) begin
            failures++;
            $display("FAIL ceiling_exact: rej %b credit %0d expected 0 %0d", coin_reject, credit, MAXC);
        end
        drive_coin(1'b0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'(MAXC)) begin
            failures++;
            $display("FAIL ceiling_over: rej %b credit %0d expected 1 %0d", coin_reject, credit, MAXC);
        end
        drive_cancel();
        pay_change(n, rb, ok);
        checks++;
        if (!ok || n != 19 || credit !== 8'd0) begin
            failures++;
            $display("FAIL ceiling_refund95: coins %0d credit %0d expected 19 0", n, credit);
        end
    endtask

    task automatic test_cancel_same_cycle();
        int n, rb;
        bit ok;
        drive_cancel();
        checks++;
        if (state_dbg !== 2'd0 || chg_req !== 1'b0) begin
            failures++;
            $display("FAIL cancel_empty: state %0d chg %b expected 0 0", state_dbg, chg_req);
        end
        drive_coin(1'b0);
        cancel = 1'b1; coin_in_en = 1'b1; coin_val = 1'b1; sel_valid = 1'b1; sel_id = 2'd0;
        tick();
        cancel = 1'b0; coin_in_en = 1'b0; sel_valid = 1'b0;
        checks++;
        if (credit !== 8'd15 || sel_reject !== 1'b1 || coin_reject !== 1'b0 || chg_req !== 1'b1 || disp_req !== 1'b0) begin
            failures++;
            $display("FAIL cancel_combo: credit %0d srej %b crej %b chg %b disp %b expected 15 1 0 1 0",
                     credit, sel_reject, coin_reject, chg_req, disp_req);
        end
        pay_change(n, rb, ok);
        checks++;
        if (!ok || n != 3 || rb != 0 || credit !== 8'd0) begin
            failures++;
            $display("FAIL cancel_combo_pay: coins %0d credit %0d expected 3 0", n, credit);
        end
    endtask

    task automatic test_busy_reject();
        int n, rb;
        bit ok;
        repeat (3) drive_coin(1'b1);
        drive_sel(2'd3);
        checks++;
        if (sel_reject !== 1'b1 || credit !== 8'd30) begin
            failures++;
            $display("FAIL busy_price50: rej %b credit %0d expected 1 30", sel_reject, credit);
        end
        drive_sel(2'd2);
        drive_coin(1'b1);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd5 || disp_req !== 1'b1) begin
            failures++;
            $display("FAIL busy_coin: rej %b credit %0d req %b expected 1 5 1", coin_reject, credit, disp_req);
        end
        drive_sel(2'd0);
        checks++;
        if (sel_reject !== 1'b1 || disp_item !== 2'd2) begin
            failures++;
            $display("FAIL busy_sel: rej %b item %0d expected 1 2", sel_reject, disp_item);
        end
        drive_cancel();
        checks++;
        if (state_dbg !== 2'd1 || credit !== 8'd5 || chg_req !== 1'b0) begin
            failures++;
            $display("FAIL busy_cancel: state %0d credit %0d chg %b expected 1 5 0", state_dbg, credit, chg_req);
        end
        drive_disp_ack();
        drive_coin(1'b0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd5 || state_dbg !== 2'd2) begin
            failures++;
            $display("FAIL change_coin: rej %b credit %0d state %0d expected 1 5 2", coin_reject, credit, state_dbg);
        end
        pay_change(n, rb, ok);
        checks++;
        if (!ok || n != 1 || credit !== 8'd0) begin
            failures++;
            $display("FAIL busy_pay: coins %0d credit %0d expected 1 0", n, credit);
        end
    endtask

    task automatic test_random_txn();
        int n, rb, mc, amt, pr;
        bit ok;
        logic v, exp_rej;
        logic [1:0] id;
        for (int t = 0; t < 8; t++) begin
            mc = 0;
            for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
                v = 1'($urandom_range(0, 1));
                amt = v ? 10 : 5;
                if (mc + amt <= MAXC) begin
                    mc += amt;
                    exp_rej = 1'b0;
                end else begin
                    exp_rej = 1'b1;
                end
                exp_q.push_back(8'(mc));
                drive_coin(v);
                exp_v = exp_q.pop_front();
                checks++;
                if (credit !== exp_v || coin_reject !== exp_rej) begin
                    failures++;
                    $display("FAIL rand_coin: credit %0d rej %b expected %0d %b", credit, coin_reject, exp_v, exp_rej);
                end
            end
            id = 2'($urandom_range(0, 3));
            pr = price_of(id);
            if (mc >= pr) begin
                exp_q.push_back(8'(id));
                drive_sel(id);
                mc -= pr;
                exp_v = exp_q.pop_front();
                checks++;
                if (disp_req !== 1'b1 || disp_item !== exp_v[1:0] || credit !== 8'(mc)) begin
                    failures++;
                    $display("FAIL rand_sel: req %b item %0d credit %0d expected 1 %0d %0d",
                             disp_req, disp_item, credit, exp_v[1:0], mc);
                end
                repeat ($urandom_range(0, 3)) tick();
                drive_disp_ack();
            end else begin
                drive_sel(id);
                checks++;
                if (sel_reject !== 1'b1 || disp_req !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_reject: rej %b req %b expected 1 0", sel_reject, disp_req);
                end
                drive_cancel();
            end
            exp_q.push_back(8'(mc / 5));
            pay_change(n, rb, ok);
            exp_v = exp_q.pop_front();
            checks++;
            if (!ok || n != int'(exp_v) || rb != 0 || credit !== 8'd0 || state_dbg !== 2'd0) begin
                failures++;
                $display("FAIL rand_pay: coins %0d rtz_bad %0d credit %0d state %0d expected %0d 0 0 0",
                         n, rb, credit, state_dbg, exp_v);
            end
        end
    endtask

    task automatic test_disp_timeout();
        int n, rb;
        bit ok;
        repeat (3) drive_coin(1'b1);
        drive_sel(2'd2);
        n = 0;
        while (disp_req === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL disp_timeout_len: cycles %0d expected 256", n);
        end
        checks++;
        if (fault !== 1'b1 || credit !== 8'd30 || chg_req !== 1'b1 || state_dbg !== 2'd2) begin
            failures++;
            $display("FAIL disp_timeout_refund: fault %b credit %0d chg %b state %0d expected 1 30 1 2",
                     fault, credit, chg_req, state_dbg);
        end
        pay_change(n, rb, ok);
        checks++;
        if (!ok || n != 6 || credit !== 8'd0 || state_dbg !== 2'd0 || fault !== 1'b1) begin
            failures++;
            $display("FAIL disp_timeout_pay: coins %0d credit %0d state %0d fault %b expected 6 0 0 1",
                     n, credit, state_dbg, fault);
        end
        drive_coin(1'b0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd0) begin
            failures++;
            $display("FAIL fault_coin: rej %b credit %0d expected 1 0", coin_reject, credit);
        end
        drive_sel(2'd0);
        checks++;
        if (sel_reject !== 1'b1 || disp_req !== 1'b0) begin
            failures++;
            $display("FAIL fault_sel: rej %b req %b expected 1 0", sel_reject, disp_req);
        end
    endtask

    task automatic test_async_reset();
        checks++;
        if (fault !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_fault: fault %b expected 1", fault);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL async_fault_clear: fault %b state %0d expected 0 0", fault, state_dbg);
        end
        tick();
        reset_n = 1'b1;
        tick();
        drive_coin(1'b0);
        drive_coin(1'b1);
        drive_cancel();
        checks++;
        if (credit !== 8'd15 || chg_req !== 1'b1 || state_dbg !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset_change: credit %0d chg %b state %0d expected 15 1 2", credit, chg_req, state_dbg);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (credit !== 8'd0 || chg_req !== 1'b0 || state_dbg !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_change: credit %0d chg %b state %0d busy %b expected 0 0 0 0",
                     credit, chg_req, state_dbg, busy);
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_halt();
        int n;
        drive_coin(1'b1);
        drive_cancel();
        n = 0;
        while (chg_req === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != 256 || fault !== 1'b1 || state_dbg !== 2'd3 || credit !== 8'd10 || busy !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter: cycles %0d fault %b state %0d credit %0d busy %b expected 256 1 3 10 0",
                     n, fault, state_dbg, credit, busy);
        end
        drive_coin(1'b0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd10) begin
            failures++;
            $display("FAIL halt_coin: rej %b credit %0d expected 1 10", coin_reject, credit);
        end
        drive_sel(2'd0);
        checks++;
        if (sel_reject !== 1'b1 || disp_req !== 1'b0) begin
            failures++;
            $display("FAIL halt_sel: rej %b req %b expected 1 0", sel_reject, disp_req);
        end
        drive_cancel();
        repeat (5) tick();
        checks++;
        if (state_dbg !== 2'd3 || chg_req !== 1'b0 || credit !== 8'd10) begin
            failures++;
            $display("FAIL halt_cancel: state %0d chg %b credit %0d expected 3 0 10", state_dbg, chg_req, credit);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_exact_pay();
        test_change();
        test_sel_reject();
        test_ceiling();
        test_cancel_same_cycle();
        test_busy_reject();
        test_random_txn();
        test_disp_timeout();
        test_async_reset();
        test_halt();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
